// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: two writeback sources (A = ALU/EX, B = load /
// multi-cycle unit) each queue writes in a small FIFO; one write per cycle is
// granted round-robin and registered onto the register file write port.
// Pending-write lookups on two read addresses feed the hazard/stall logic.

// Per-source write queue. Exposes every slot's valid bit and address so the
// top level can search queued writes for pending hazards.
module rwa_fifo #(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic               clock,
  input  logic               resetN,
  input  logic               push_req,
  input  logic               pop,
  input  logic [4:0]         in_addr,
  input  logic [31:0]        in_data,
  output logic               ready,
  output logic               nonempty,
  output logic [4:0]         head_addr,
  output logic [31:0]        head_data,
  output logic [DEPTH-1:0]   entry_valid,
  output logic [DEPTH*5-1:0] entry_addr
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [4:0]       addr_mem_r [DEPTH];
  logic [31:0]      data_mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             ready_s;
  logic             nonempty_s;
  logic             push_s;
  logic             pop_s;
  logic [DEPTH-1:0]   entry_valid_s;
  logic [DEPTH*5-1:0] entry_addr_s;

  // Ready depends on the stored count only, so a full queue stays closed even
  // in a cycle where its head is being popped.
  assign ready_s    = (count_r != FULL_CNT);
  assign nonempty_s = (count_r != (PTR_W+1)'(0));
  assign push_s     = push_req & ready_s;
  assign pop_s      = pop & nonempty_s;

  assign ready     = ready_s;
  assign nonempty  = nonempty_s;
  assign head_addr = addr_mem_r[rd_ptr_r];
  assign head_data = data_mem_r[rd_ptr_r];

  // Storage: write the incoming entry at the tail slot on an accepted push.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_r[i] <= 5'd0;
        data_mem_r[i] <= 32'd0;
      end
    end else if (push_s) begin
      addr_mem_r[wr_ptr_r] <= in_addr;
      data_mem_r[wr_ptr_r] <= in_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= (PTR_W+1)'(0);
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Slot i holds a live entry when its distance from the read pointer is
  // below the current occupancy.
  always_comb begin
    entry_valid_s = '0;
    entry_addr_s  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ({1'b0, PTR_W'(i) - rd_ptr_r} < count_r) begin
        entry_valid_s[i] = 1'b1;
      end else begin
        entry_valid_s[i] = 1'b0;
      end
      entry_addr_s[i*5 +: 5] = addr_mem_r[i];
    end
  end

  assign entry_valid = entry_valid_s;
  assign entry_addr  = entry_addr_s;

endmodule

module regfile_write_arbiter #(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        aValid,
  output logic        aReady,
  input  logic [4:0]  aAddr,
  input  logic [31:0] aData,
  input  logic        bValid,
  output logic        bReady,
  input  logic [4:0]  bAddr,
  input  logic [31:0] bData,
  output logic        regWrite,
  output logic [4:0]  writeRegister,
  output logic [31:0] writeData,
  input  logic [4:0]  lookupReg1,
  input  logic [4:0]  lookupReg2,
  output logic        pendingHit1,
  output logic        pendingHit2
);

  typedef enum logic {RR_A = 1'b0, RR_B = 1'b1} rr_state_t;

  logic               a_ready_s, b_ready_s;
  logic               a_nonempty_s, b_nonempty_s;
  logic [4:0]         a_head_addr_s, b_head_addr_s;
  logic [31:0]        a_head_data_s, b_head_data_s;
  logic [DEPTH-1:0]   a_entry_valid_s, b_entry_valid_s;
  logic [DEPTH*5-1:0] a_entry_addr_s, b_entry_addr_s;
  logic               grant_a_s, grant_b_s;
  logic               hit1_s, hit2_s;

  rr_state_t          rr_r;
  logic               reg_write_r;
  logic [4:0]         write_register_r;
  logic [31:0]        write_data_r;

  // A write targeting lookup is pending if any live queue slot or the output
  // stage (while it is still driving regWrite) names it; register 0 never matches.
  function automatic logic pending_match(
    input logic [DEPTH-1:0]   va,
    input logic [DEPTH*5-1:0] aa,
    input logic [DEPTH-1:0]   vb,
    input logic [DEPTH*5-1:0] ab,
    input logic               out_v,
    input logic [4:0]         out_a,
    input logic [4:0]         lookup
  );
    logic hit;
    hit = 1'b0;
    if (lookup != 5'd0) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (va[i] && (aa[i*5 +: 5] == lookup)) hit = 1'b1;
        if (vb[i] && (ab[i*5 +: 5] == lookup)) hit = 1'b1;
      end
      if (out_v && (out_a == lookup)) hit = 1'b1;
    end
    return hit;
  endfunction

  rwa_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo_a (
    .clock       (clock),
    .resetN      (resetN),
    .push_req    (aValid),
    .pop         (grant_a_s),
    .in_addr     (aAddr),
    .in_data     (aData),
    .ready       (a_ready_s),
    .nonempty    (a_nonempty_s),
    .head_addr   (a_head_addr_s),
    .head_data   (a_head_data_s),
    .entry_valid (a_entry_valid_s),
    .entry_addr  (a_entry_addr_s)
  );

  rwa_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo_b (
    .clock       (clock),
    .resetN      (resetN),
    .push_req    (bValid),
    .pop         (grant_b_s),
    .in_addr     (bAddr),
    .in_data     (bData),
    .ready       (b_ready_s),
    .nonempty    (b_nonempty_s),
    .head_addr   (b_head_addr_s),
    .head_data   (b_head_data_s),
    .entry_valid (b_entry_valid_s),
    .entry_addr  (b_entry_addr_s)
  );

  // Grant selection: a lone requester always wins; on contention rr_r decides.
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    case ({a_nonempty_s, b_nonempty_s})
      2'b10: grant_a_s = 1'b1;
      2'b01: grant_b_s = 1'b1;
      2'b11: begin
        if (rr_r == RR_A) begin
          grant_a_s = 1'b1;
        end else begin
          grant_b_s = 1'b1;
        end
      end
      default: begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
      end
    endcase
  end

  // Round-robin pointer and registered write port; addr-0 grants drain the
  // queue but never raise regWrite.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      rr_r             <= RR_A;
      reg_write_r      <= 1'b0;
      write_register_r <= 5'd0;
      write_data_r     <= 32'd0;
    end else if (grant_a_s) begin
      rr_r             <= RR_B;
      reg_write_r      <= (a_head_addr_s != 5'd0);
      write_register_r <= a_head_addr_s;
      write_data_r     <= a_head_data_s;
    end else if (grant_b_s) begin
      rr_r             <= RR_A;
      reg_write_r      <= (b_head_addr_s != 5'd0);
      write_register_r <= b_head_addr_s;
      write_data_r     <= b_head_data_s;
    end else begin
      reg_write_r      <= 1'b0;
    end
  end

  // Hazard lookups for the two decode read ports.
  always_comb begin
    hit1_s = pending_match(a_entry_valid_s, a_entry_addr_s, b_entry_valid_s,
                           b_entry_addr_s, reg_write_r, write_register_r, lookupReg1);
    hit2_s = pending_match(a_entry_valid_s, a_entry_addr_s, b_entry_valid_s,
                           b_entry_addr_s, reg_write_r, write_register_r, lookupReg2);
  end

  assign aReady        = a_ready_s;
  assign bReady        = b_ready_s;
  assign regWrite      = reg_write_r;
  assign writeRegister = write_register_r;
  assign writeData     = write_data_r;
  assign pendingHit1   = hit1_s;
  assign pendingHit2   = hit2_s;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: a hand-computed vector table, directed
// multi-cycle sequences, and random traffic against a queue-based model.
module tb_regfile_write_arbiter;

  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        resetN;
  logic        aValid, bValid;
  logic        aReady, bReady;
  logic [4:0]  aAddr, bAddr;
  logic [31:0] aData, bData;
  logic        regWrite;
  logic [4:0]  writeRegister;
  logic [31:0] writeData;
  logic [4:0]  lookupReg1, lookupReg2;
  logic        pendingHit1, pendingHit2;

  always #5 clock = ~clock;

  regfile_write_arbiter #(.DEPTH(DEPTH), .PTR_W(1)) dut (
    .clock(clock), .resetN(resetN),
    .aValid(aValid), .aReady(aReady), .aAddr(aAddr), .aData(aData),
    .bValid(bValid), .bReady(bReady), .bAddr(bAddr), .bData(bData),
    .regWrite(regWrite), .writeRegister(writeRegister), .writeData(writeData),
    .lookupReg1(lookupReg1), .lookupReg2(lookupReg2),
    .pendingHit1(pendingHit1), .pendingHit2(pendingHit2)
  );

  int n_vec = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  typedef struct { logic [4:0] addr; logic [31:0] data; } ent_t;
  ent_t        qa[$];
  ent_t        qb[$];
  int          rr_m;      // 0: A preferred on contention, 1: B preferred
  logic        exp_rw;
  logic [4:0]  exp_wr;
  logic [31:0] exp_wd;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic model_hit(input logic [4:0] lk);
    if (lk == 5'd0) return 1'b0;
    foreach (qa[i]) if (qa[i].addr == lk) return 1'b1;
    foreach (qb[i]) if (qb[i].addr == lk) return 1'b1;
    if (exp_rw && exp_wr == lk) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    qa.delete(); qb.delete();
    rr_m = 0; exp_rw = 1'b0; exp_wr = 5'd0; exp_wd = 32'd0;
  endtask

  // One clock cycle: drive, check combinational outputs, advance model, check write port.
  task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                      input logic [4:0] l1, input logic [4:0] l2);
    ent_t e;
    logic pa, pb;
    @(negedge clock);
    aValid = av; aAddr = aa; aData = ad;
    bValid = bv; bAddr = ba; bData = bd;
    lookupReg1 = l1; lookupReg2 = l2;
    #1;
    check("ready_hit", {60'd0, aReady, bReady, pendingHit1, pendingHit2},
          {60'd0, (qa.size() < DEPTH), (qb.size() < DEPTH), model_hit(l1), model_hit(l2)});
    pa = av && (qa.size() < DEPTH);
    pb = bv && (qb.size() < DEPTH);
    @(posedge clock);
    if (qa.size() > 0 && (qb.size() == 0 || rr_m == 0)) begin
      e = qa.pop_front();
      exp_rw = (e.addr != 5'd0); exp_wr = e.addr; exp_wd = e.data; rr_m = 1;
    end else if (qb.size() > 0) begin
      e = qb.pop_front();
      exp_rw = (e.addr != 5'd0); exp_wr = e.addr; exp_wd = e.data; rr_m = 0;
    end else begin
      exp_rw = 1'b0;
    end
    if (pa) begin e.addr = aa; e.data = ad; qa.push_back(e); end
    if (pb) begin e.addr = ba; e.data = bd; qb.push_back(e); end
    #1;
    check("write_port", {26'd0, regWrite, writeRegister, writeData},
          {26'd0, exp_rw, exp_wr, exp_wd});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    resetN = 1'b0;
    aValid = 1'b0; bValid = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetN = 1'b1;
    model_clear();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic av; logic [4:0] aa; logic [31:0] ad;
    logic bv; logic [4:0] ba; logic [31:0] bd;
    logic [4:0] l1; logic [4:0] l2;
    logic [3:0] ex_pre;   // {aReady, bReady, pendingHit1, pendingHit2} before the edge
    logic ex_rw; logic [4:0] ex_wr; logic [31:0] ex_wd;  // after the edge
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'h0,    5'd5, 5'd9, 4'b1100, 1'b0, 5'd0, 32'h0};
    tbl[1]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,    5'd5, 5'd9, 4'b1110, 1'b1, 5'd5, 32'h11};
    tbl[2]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,    5'd5, 5'd9, 4'b1110, 1'b0, 5'd5, 32'h11};
    tbl[3]  = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd0, 32'hDEAD, 5'd0, 5'd0, 4'b1100, 1'b0, 5'd5, 32'h11};
    tbl[4]  = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd7, 32'h1,    5'd0, 5'd7, 4'b1100, 1'b0, 5'd0, 32'hDEAD};
    tbl[5]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,    5'd0, 5'd7, 4'b1101, 1'b1, 5'd7, 32'h1};
    tbl[6]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,    5'd7, 5'd7, 4'b1111, 1'b0, 5'd7, 32'h1};
    tbl[7]  = '{1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0,    5'd9, 5'd7, 4'b1100, 1'b0, 5'd7, 32'h1};
    tbl[8]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,    5'd9, 5'd7, 4'b1110, 1'b1, 5'd9, 32'h99};
    tbl[9]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,    5'd9, 5'd7, 4'b1110, 1'b0, 5'd9, 32'h99};
    tbl[10] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,    5'd9, 5'd7, 4'b1100, 1'b0, 5'd9, 32'h99};

    resetN = 1'b0;
    aValid = 1'b0; aAddr = 5'd0; aData = 32'd0;
    bValid = 1'b0; bAddr = 5'd0; bData = 32'd0;
    lookupReg1 = 5'd5; lookupReg2 = 5'd0;
    model_clear();
    #1;
    check("reset_out", {26'd0, regWrite, writeRegister, writeData}, 64'd0);
    check("reset_hit", {62'd0, pendingHit1, pendingHit2}, 64'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetN = 1'b1;
    #1;
    check("release_ready", {62'd0, aReady, bReady}, 64'd3);

    // Basic write, latency, register 0 and pending-hit windows.
    for (int i = 0; i < 11; i++) begin
      @(negedge clock);
      aValid = tbl[i].av; aAddr = tbl[i].aa; aData = tbl[i].ad;
      bValid = tbl[i].bv; bAddr = tbl[i].ba; bData = tbl[i].bd;
      lookupReg1 = tbl[i].l1; lookupReg2 = tbl[i].l2;
      #1;
      check($sformatf("tbl%0d_pre", i), {60'd0, aReady, bReady, pendingHit1, pendingHit2},
            {60'd0, tbl[i].ex_pre});
      @(posedge clock);
      #1;
      check($sformatf("tbl%0d_post", i), {26'd0, regWrite, writeRegister, writeData},
            {26'd0, tbl[i].ex_rw, tbl[i].ex_wr, tbl[i].ex_wd});
    end

    // Both ports streaming: grants alternate starting at A, order kept per port.
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 5'(1 + i), 32'hA000 + 32'(i), 1'b1, 5'(16 + i), 32'hB000 + 32'(i),
           5'(1 + i), 5'(16 + i));
    end
    idle(6);

    // Fill A to DEPTH while B holds the port; extra push is dropped.
    apply_reset();
    step(1'b0, 5'd0, 32'h0,  1'b1, 5'd20, 32'hB0, 5'd0, 5'd0);
    step(1'b1, 5'd3, 32'hA0, 1'b1, 5'd21, 32'hB1, 5'd3, 5'd21);
    step(1'b1, 5'd4, 32'hA1, 1'b1, 5'd22, 32'hB2, 5'd4, 5'd22);
    step(1'b1, 5'd5, 32'hA2, 1'b1, 5'd23, 32'hB3, 5'd5, 5'd23);
    check("a_full", {63'd0, aReady}, 64'd0);
    step(1'b1, 5'd6, 32'hA3, 1'b0, 5'd0, 32'h0, 5'd6, 5'd0);
    check("a_ready_back", {63'd0, aReady}, 64'd1);
    idle(6);

    // Asynchronous reset with both queues holding work and a write in flight.
    apply_reset();
    step(1'b1, 5'd10, 32'hC0, 1'b1, 5'd11, 32'hC1, 5'd0, 5'd0);
    step(1'b1, 5'd12, 32'hC2, 1'b1, 5'd13, 32'hC3, 5'd12, 5'd13);
    @(negedge clock);
    aValid = 1'b0; bValid = 1'b0;
    lookupReg1 = 5'd12; lookupReg2 = 5'd13;
    #2;
    resetN = 1'b0;
    #1;
    check("async_rst_out", {26'd0, regWrite, writeRegister, writeData}, 64'd0);
    check("async_rst_hit", {62'd0, pendingHit1, pendingHit2}, 64'd0);
    model_clear();
    @(posedge clock);
    @(negedge clock);
    resetN = 1'b1;
    idle(3);
    step(1'b1, 5'd14, 32'hD0, 1'b1, 5'd15, 32'hD1, 5'd14, 5'd15);
    idle(3);

    // Random traffic against the model.
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), 32'($urandom),
           $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), 32'($urandom),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
